// File: rtl/rf_prbs_checker.sv
// Receive-side PRBS checker. Self-synchronises a local LFSR to the incoming
// sliced bit stream, declares lock after LOCK_CNT consecutive correct
// predictions, then free-runs the LFSR and counts checked bits and bit errors.
// Lock is dropped when a WIN_LEN-bit window collects LOSS_THR or more errors.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   bit_in   received data bit, qualified by bit_stb
//   bit_stb  one-cycle strobe for bit_in; may be high every cycle
//   clr      synchronous clear of bit_cnt and err_cnt
//   locked   checker is in the locked state
//   err_stb  one-cycle pulse per erroneous bit while locked
//   bit_cnt  bits checked while locked, saturating
//   err_cnt  errors counted while locked, saturating
module rf_prbs_checker #(
  parameter int unsigned PRBS_W   = 7,
  parameter int unsigned TAP_A    = 7,
  parameter int unsigned TAP_B    = 6,
  parameter int unsigned LOCK_CNT = 16,
  parameter int unsigned WIN_LEN  = 256,
  parameter int unsigned LOSS_THR = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_stb,
  input  logic             clr,
  output logic             locked,
  output logic             err_stb,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned FillW  = $clog2(PRBS_W + 1);
  localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
  localparam int unsigned WinW   = $clog2(WIN_LEN + 1);
  localparam int unsigned WerrW  = $clog2(LOSS_THR + 1);

  localparam logic [FillW-1:0]  FillLast  = FillW'(PRBS_W - 1);
  localparam logic [MatchW-1:0] MatchLast = MatchW'(LOCK_CNT - 1);
  localparam logic [WinW-1:0]   WinLast   = WinW'(WIN_LEN - 1);
  localparam logic [WerrW-1:0]  WerrThr   = WerrW'(LOSS_THR);
  localparam logic [CNT_W-1:0]  CntMax    = '1;

  typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

  state_e             state_q, state_d;
  logic [PRBS_W-1:0]  sr_q, sr_d;
  logic [FillW-1:0]   fill_q, fill_d;
  logic [MatchW-1:0]  match_q, match_d;
  logic [WinW-1:0]    win_q, win_d;
  logic [WerrW-1:0]   win_err_q, win_err_d;
  logic [WerrW-1:0]   win_err_inc;
  logic               err_stb_q, err_stb_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               pred;
  logic               err;

  // sr[0] holds the newest bit, so tap k looks k bits back in the stream.
  assign pred = sr_q[TAP_A-1] ^ sr_q[TAP_B-1];
  assign err  = bit_in ^ pred;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_d       = win_q;
    win_err_d   = win_err_q;
    win_err_inc = win_err_q;
    err_stb_d   = 1'b0;
    bit_cnt_d   = bit_cnt_q;
    err_cnt_d   = err_cnt_q;

    if (bit_stb) begin
      unique case (state_q)
        StSearch: begin
          sr_d = {sr_q[PRBS_W-2:0], bit_in};
          if (fill_q == FillLast) begin
            state_d = StVerify;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end

        StVerify: begin
          // Keep self-syncing on the received bit; an all-zero sr is the LFSR
          // lock-up state and must never count towards lock.
          sr_d = {sr_q[PRBS_W-2:0], bit_in};
          if (!err && (sr_q != '0)) begin
            if (match_q == MatchLast) begin
              state_d   = StLocked;
              match_d   = '0;
              win_d     = '0;
              win_err_d = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
          end
        end

        StLocked: begin
          // Free-run so received errors cannot corrupt the reference.
          sr_d      = {sr_q[PRBS_W-2:0], pred};
          err_stb_d = err;
          if (bit_cnt_q != CntMax) bit_cnt_d = bit_cnt_q + 1'b1;
          if (err && (err_cnt_q != CntMax)) err_cnt_d = err_cnt_q + 1'b1;
          if (err && (win_err_q != WerrThr)) win_err_inc = win_err_q + 1'b1;
          if (win_q == WinLast) begin
            win_d     = '0;
            win_err_d = '0;
            if (win_err_inc >= WerrThr) begin
              state_d = StSearch;
              fill_d  = '0;
            end
          end else begin
            win_d     = win_q + 1'b1;
            win_err_d = win_err_inc;
          end
        end

        default: state_d = StSearch;
      endcase
    end

    // Clear takes priority over counting the bit strobed in the same cycle.
    if (clr) begin
      bit_cnt_d = '0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StSearch;
      sr_q      <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      win_q     <= '0;
      win_err_q <= '0;
      err_stb_q <= 1'b0;
      bit_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      win_q     <= win_d;
      win_err_q <= win_err_d;
      err_stb_q <= err_stb_d;
      bit_cnt_q <= bit_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign locked  = (state_q == StLocked);
  assign err_stb = err_stb_q;
  assign bit_cnt = bit_cnt_q;
  assign err_cnt = err_cnt_q;

endmodule
